// File: rtl/pipeline_skid_buffer_pkg.sv
// Shared types and constants for the pipeline skid buffer.
package pipeline_skid_buffer_pkg;

    // Occupancy of the two-entry buffer, in main-then-skid order.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    localparam int unsigned DEFAULT_ENTRY_WIDTH = 4;

    // Occupancy from the two valid bits. The illegal main-empty/skid-held combination
    // reports FULL so the top can promote the stranded skid entry.
    function automatic skid_state_t state_of(input logic main_valid, input logic skid_valid);
        if (skid_valid) begin
            return FULL;
        end else if (main_valid) begin
            return BUSY;
        end
        return EMPTY;
    endfunction

endpackage

// File: rtl/pipeline_skid_buffer_skid_entry_reg.sv
// One valid + data slot of the skid buffer.
// Priority: rst > init > clear > load > drop.
module skid_entry_reg
    import pipeline_skid_buffer_pkg::*;
#(
    parameter int unsigned ENTRY_WIDTH = DEFAULT_ENTRY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   init_valid,
    input  logic [ENTRY_WIDTH-1:0] init_data,
    input  logic                   clear,
    input  logic                   load,
    input  logic [ENTRY_WIDTH-1:0] load_data,
    input  logic                   drop,
    output logic                   valid,
    output logic [ENTRY_WIDTH-1:0] data
);

    // Slot state: data only moves when the slot is (re)loaded, so a cleared or
    // dropped slot keeps its last payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (init) begin
            valid <= init_valid;
            data  <= init_data;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry skid buffer: in_ready and out_valid/out_data come straight from registers,
// so no combinational path crosses the block in either direction.
module pipeline_skid_buffer
    import pipeline_skid_buffer_pkg::*;
#(
    parameter int unsigned ENTRY_WIDTH = DEFAULT_ENTRY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_sH,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [ENTRY_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [ENTRY_WIDTH-1:0] out_data,
    input  logic                   out_ready,
    input  logic                   init,
    input  logic                   init_main_valid,
    input  logic                   init_skid_valid,
    input  logic [ENTRY_WIDTH-1:0] init_main_data,
    input  logic [ENTRY_WIDTH-1:0] init_skid_data,
    output logic                   current_main_valid,
    output logic                   current_skid_valid,
    output logic [ENTRY_WIDTH-1:0] current_main_data,
    output logic [ENTRY_WIDTH-1:0] current_skid_data
);

    logic                   main_valid;
    logic                   skid_valid;
    logic [ENTRY_WIDTH-1:0] main_data;
    logic [ENTRY_WIDTH-1:0] skid_data;

    logic                   in_fire;
    logic                   out_fire;
    skid_state_t            state;

    logic                   main_load;
    logic [ENTRY_WIDTH-1:0] main_load_data;
    logic                   main_drop;
    logic                   skid_load;
    logic                   skid_drop;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign state    = state_of(main_valid, skid_valid);

    assign current_main_valid = main_valid;
    assign current_skid_valid = skid_valid;
    assign current_main_data  = main_data;
    assign current_skid_data  = skid_data;

    // Handshake-driven slot moves for each occupancy state.
    always_comb begin
        main_load      = 1'b0;
        main_load_data = in_data;
        main_drop      = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        case (state)
            EMPTY: begin
                main_load = in_fire;
            end
            BUSY: begin
                if (in_fire) begin
                    if (out_fire) begin
                        main_load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                    end
                end else if (out_fire) begin
                    main_drop = 1'b1;
                end
            end
            FULL: begin
                // An empty main with a held skid (only reachable via init) is
                // treated like a drained main so the entry is not stranded.
                if (out_fire || !main_valid) begin
                    main_load      = 1'b1;
                    main_load_data = skid_data;
                    skid_drop      = 1'b1;
                end
            end
            default: begin
                main_load = 1'b0;
            end
        endcase
    end

    skid_entry_reg #(
        .ENTRY_WIDTH(ENTRY_WIDTH)
    ) u_main (
        .clk        (clk),
        .rst        (rst_sH),
        .init       (init),
        .init_valid (init_main_valid),
        .init_data  (init_main_data),
        .clear      (flush),
        .load       (main_load),
        .load_data  (main_load_data),
        .drop       (main_drop),
        .valid      (main_valid),
        .data       (main_data)
    );

    skid_entry_reg #(
        .ENTRY_WIDTH(ENTRY_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst_sH),
        .init       (init),
        .init_valid (init_skid_valid),
        .init_data  (init_skid_data),
        .clear      (flush),
        .load       (skid_load),
        .load_data  (in_data),
        .drop       (skid_drop),
        .valid      (skid_valid),
        .data       (skid_data)
    );

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Bench for pipeline_skid_buffer: directed scenarios plus a randomized run checked
// against an in-order queue model of the buffer contents.
module tb_pipeline_skid_buffer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_sH;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         init;
    logic         init_main_valid;
    logic         init_skid_valid;
    logic [W-1:0] init_main_data;
    logic [W-1:0] init_skid_data;
    logic         current_main_valid;
    logic         current_skid_valid;
    logic [W-1:0] current_main_data;
    logic [W-1:0] current_skid_data;

    int checks;
    int failures;

    // Model: entries held, oldest first; at most two.
    logic [W-1:0] mq[$];

    pipeline_skid_buffer #(
        .ENTRY_WIDTH(W)
    ) dut (
        .clk                (clk),
        .rst_sH             (rst_sH),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_ready          (out_ready),
        .init               (init),
        .init_main_valid    (init_main_valid),
        .init_skid_valid    (init_skid_valid),
        .init_main_data     (init_main_data),
        .init_skid_data     (init_skid_data),
        .current_main_valid (current_main_valid),
        .current_skid_valid (current_skid_valid),
        .current_main_data  (current_main_data),
        .current_skid_data  (current_skid_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        int sz;
        sz = mq.size();
        if (rst_sH) begin
            mq.delete();
        end else if (init) begin
            mq.delete();
            if (init_main_valid) mq.push_back(init_main_data);
            if (init_skid_valid) mq.push_back(init_skid_data);
        end else if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) mq.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_sH = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        init = 1'b0; init_main_valid = 1'b0; init_skid_valid = 1'b0;
        init_main_data = '0; init_skid_data = '0;
    endtask

    task automatic load_state(input logic mv, input logic [W-1:0] md,
                              input logic sv, input logic [W-1:0] sd);
        idle_inputs();
        init = 1'b1; init_main_valid = mv; init_main_data = md;
        init_skid_valid = sv; init_skid_data = sd;
        tick();
        init = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = 1'b1; in_data = 4'h9; rst_sH = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 4'h0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (current_skid_valid !== 1'b0 || current_skid_data !== 4'h0) begin
            failures++;
            $display("FAIL reset_skid got=%b/%h exp=0/0", current_skid_valid, current_skid_data);
        end
    endtask

    task automatic test_first_entry();
        idle_inputs();
        in_valid = 1'b1; in_data = 4'h1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL first_in_ready got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h1) begin
            failures++; $display("FAIL first_latency got=%b/%h exp=1/1", out_valid, out_data);
        end
        checks++;
        if (current_skid_valid !== 1'b0) begin
            failures++; $display("FAIL first_skid got=%b exp=0", current_skid_valid);
        end
    endtask

    task automatic test_fill_skid();
        load_state(1'b1, 4'hf, 1'b0, 4'h0);
        in_valid = 1'b1; in_data = 4'h2; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (current_skid_valid !== 1'b1 || current_skid_data !== 4'h2) begin
            failures++;
            $display("FAIL fill_skid got=%b/%h exp=1/2", current_skid_valid, current_skid_data);
        end
        checks++;
        if (in_ready !== 1'b0 || out_data !== 4'hf) begin
            failures++; $display("FAIL fill_out got=%b/%h exp=0/f", in_ready, out_data);
        end
    endtask

    task automatic test_drain_full();
        load_state(1'b1, 4'hf, 1'b1, 4'h2);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h5;
        #1;
        checks++;
        if (out_data !== 4'hf || in_ready !== 1'b0) begin
            failures++; $display("FAIL drain_now got=%h/%b exp=f/0", out_data, in_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (current_main_valid !== 1'b1 || current_main_data !== 4'h2 ||
            current_skid_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_next got=%b/%h/%b exp=1/2/0", current_main_valid,
                     current_main_data, current_skid_valid);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        rst_sH = 1'b1;
        tick();
        rst_sH = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== W'(i) || current_skid_valid !== 1'b0) begin
                failures++;
                $display("FAIL stream_%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, out_data,
                         current_skid_valid, W'(i));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        load_state(1'b1, 4'ha, 1'b1, 4'hb);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h7;
        tick();
        idle_inputs();
        checks++;
        if (current_main_valid !== 1'b0 || current_skid_valid !== 1'b0) begin
            failures++; $display("FAIL flush_valid got=%b/%b exp=0/0",
                                 current_main_valid, current_skid_valid);
        end
        checks++;
        if (current_main_data !== 4'ha || current_skid_data !== 4'hb) begin
            failures++; $display("FAIL flush_data got=%h/%h exp=a/b",
                                 current_main_data, current_skid_data);
        end
    endtask

    task automatic test_reset_priority();
        load_state(1'b1, 4'ha, 1'b1, 4'hb);
        rst_sH = 1'b1; init = 1'b1;
        init_main_valid = 1'b1; init_main_data = 4'h3;
        init_skid_valid = 1'b1; init_skid_data = 4'h4;
        tick();
        idle_inputs();
        checks++;
        if (current_main_valid !== 1'b0 || current_skid_valid !== 1'b0 ||
            current_main_data !== 4'h0 || current_skid_data !== 4'h0) begin
            failures++;
            $display("FAIL rst_over_init got=%b/%b/%h/%h exp=0/0/0/0", current_main_valid,
                     current_skid_valid, current_main_data, current_skid_data);
        end
    endtask

    task automatic test_random();
        logic mv;
        idle_inputs();
        rst_sH = 1'b1;
        tick();
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 31) == 0) flush = 1'b1;
            if ($urandom_range(0, 63) == 0) rst_sH = 1'b1;
            if ($urandom_range(0, 47) == 0) begin
                mv = 1'($urandom);
                init = 1'b1;
                init_main_valid = mv; init_main_data = W'($urandom);
                init_skid_valid = mv & 1'($urandom); init_skid_data = W'($urandom);
            end
            #1;
            checks++;
            if (in_ready !== (mq.size() < 2)) begin
                failures++;
                $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, mq.size() < 2);
            end
            checks++;
            if (out_valid !== (mq.size() > 0)) begin
                failures++;
                $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c, out_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++;
                if (out_data !== mq[0]) begin
                    failures++;
                    $display("FAIL rand_out_data c=%0d got=%h exp=%h", c, out_data, mq[0]);
                end
            end
            checks++;
            if (current_skid_valid !== (mq.size() > 1)) begin
                failures++;
                $display("FAIL rand_skid_valid c=%0d got=%b exp=%b", c, current_skid_valid,
                         mq.size() > 1);
            end
            if (mq.size() > 1) begin
                checks++;
                if (current_skid_data !== mq[1]) begin
                    failures++;
                    $display("FAIL rand_skid_data c=%0d got=%h exp=%h", c, current_skid_data,
                             mq[1]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        test_reset();
        test_first_entry();
        test_fill_skid();
        test_drain_full();
        test_back_to_back();
        test_flush();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
